// File: rtl/seq_divider_10bit_pkg.sv
// Shared widths, state encoding and divide-by-zero constant for the iterative
// restoring divider.
package seq_divider_10bit_pkg;

    localparam int DW = 10;
    localparam int VW = 4;
    localparam int CW = $clog2(DW);

    localparam logic [DW-1:0] DIV0_QUOT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_10bit_if.sv
// Request/result bundle for the divider; the requester drives operands and
// start, the divider returns status and registered results.
interface seq_divider_10bit_if;
    import seq_divider_10bit_pkg::*;

    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_10bit_trial_subtractor.sv
// Combinational W-bit a - b as a ripple of full-adder cells with inverted b
// and carry-in 1; a set carry-out means the subtraction did not borrow.
module seq_divider_10bit_trial_subtractor #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-2:0] o_diff,
    output logic         o_no_borrow
);

    logic [W-1:0] w_nb;
    logic [W-1:0] w_carry;

    assign w_nb = ~i_b;

    // The top difference bit is zero whenever no borrow occurs in a restoring
    // step, so the last cell only produces its carry.
    always_comb begin
        w_carry    = '0;
        w_carry[0] = 1'b1;
        o_diff     = '0;
        for (int i = 0; i < W - 1; i++) begin
            o_diff[i]    = i_a[i] ^ w_nb[i] ^ w_carry[i];
            w_carry[i+1] = (i_a[i] & w_nb[i]) | (i_a[i] & w_carry[i]) | (w_nb[i] & w_carry[i]);
        end
    end

    assign o_no_borrow = (i_a[W-1] & w_nb[W-1]) | (i_a[W-1] & w_carry[W-1]) |
                         (w_nb[W-1] & w_carry[W-1]);

endmodule

// File: rtl/seq_divider_10bit.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, with the
// quotient shifted into the dividend register as the dividend shifts out.
module seq_divider_10bit
    import seq_divider_10bit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    seq_divider_10bit_if.slave   bus
);

    state_t        r_state;
    state_t        w_next_state;
    logic [DW-1:0] r_dreg;
    logic [VW-1:0] r_prem;
    logic [VW-1:0] r_divisor;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_quot;
    logic [VW-1:0] r_rem;
    logic          r_dbz;

    logic [VW:0]   w_t;
    logic [VW-1:0] w_diff;
    logic [VW-1:0] w_prem_next;
    logic          w_no_borrow;
    logic          w_accept;
    logic          w_div0;

    assign w_accept = (r_state == ST_IDLE) && bus.start;
    assign w_div0   = (bus.divisor == '0);

    // The partial remainder never reaches the divisor, so t fits in VW+1 bits.
    assign w_t = {r_prem, r_dreg[DW-1]};

    seq_divider_10bit_trial_subtractor #(
        .W (VW + 1)
    ) u_trial_subtractor (
        .i_a         (w_t),
        .i_b         ({1'b0, r_divisor}),
        .o_diff      (w_diff),
        .o_no_borrow (w_no_borrow)
    );

    assign w_prem_next = w_no_borrow ? w_diff : w_t[VW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_next_state = w_div0 ? ST_DONE : ST_RUN;
            ST_RUN:  if (r_cnt == '0) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dreg    <= '0;
            r_prem    <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_dbz     <= 1'b0;
        end else if (w_accept) begin
            r_dreg    <= bus.dividend;
            r_prem    <= '0;
            r_divisor <= bus.divisor;
            r_cnt     <= CW'(DW - 1);
            r_quot    <= w_div0 ? DIV0_QUOT : '0;
            r_rem     <= '0;
            r_dbz     <= w_div0;
        end else if (r_state == ST_RUN) begin
            r_prem <= w_prem_next;
            r_dreg <= {r_dreg[DW-2:0], w_no_borrow};
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_quot <= {r_dreg[DW-2:0], w_no_borrow};
                r_rem  <= w_prem_next;
            end
        end
    end

    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.done        = (r_state == ST_DONE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider_10bit.sv
// Scenario bench for seq_divider_10bit: expected results are queued when an
// operation is issued and compared when the divider reports done.
module tb_seq_divider_10bit;
    import seq_divider_10bit_pkg::*;

    typedef struct {
        logic [DW-1:0] quot;
        logic [VW-1:0] rem;
        logic          dbz;
        int            lat;
    } exp_t;

    exp_t sb[$];

    logic clk;
    logic rst_n;
    int   nVec = 0;
    int   nErr = 0;

    seq_divider_10bit_if bus();

    seq_divider_10bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pushExpected(input logic [DW-1:0] dd, input logic [VW-1:0] dv);
        exp_t e;
        if (dv == '0) begin
            e.quot = DIV0_QUOT;
            e.rem  = '0;
            e.dbz  = 1'b1;
            e.lat  = 0;
        end else begin
            e.quot = DW'(dd / DW'(dv));
            e.rem  = VW'(dd % DW'(dv));
            e.dbz  = 1'b0;
            e.lat  = DW;
        end
        sb.push_back(e);
    endtask

    // Issues one operation and watches it until busy drops; optional spurious
    // start pulses and a mid-run reset are injected at the given cycle indices.
    task automatic run_op(
        input  logic [DW-1:0] dd,
        input  logic [VW-1:0] dv,
        input  int            ghostA,
        input  int            ghostB,
        input  int            abortAt,
        output int            lat,
        output int            busyCnt,
        output int            donePulses,
        output logic [DW-1:0] q,
        output logic [VW-1:0] r,
        output logic          dz
    );
        lat = -1;
        busyCnt = 0;
        donePulses = 0;
        q = '0;
        r = '0;
        dz = 1'b0;
        if (abortAt < 0) pushExpected(dd, dv);
        bus.dividend = dd;
        bus.divisor  = dv;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = DW'($urandom);
        bus.divisor  = VW'($urandom);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == abortAt) begin
                rst_n = 1'b0;
                #1;
                break;
            end
            if (bus.busy !== 1'b1) break;
            busyCnt++;
            if (bus.done === 1'b1) begin
                donePulses++;
                if (lat < 0) begin
                    lat = cyc;
                    q   = bus.quotient;
                    r   = bus.remainder;
                    dz  = bus.div_by_zero;
                end
            end
            if (cyc == ghostA || cyc == ghostB) begin
                bus.start    = 1'b1;
                bus.dividend = DW'(50);
                bus.divisor  = VW'(5);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        nVec++; if (bus.busy !== 1'b0) begin nErr++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        nVec++; if (bus.done !== 1'b0) begin nErr++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        nVec++; if (bus.quotient !== '0) begin nErr++; $display("[TB] FAIL reset_quot: got %0d expected 0", bus.quotient); end
        nVec++; if (bus.remainder !== '0) begin nErr++; $display("[TB] FAIL reset_rem: got %0d expected 0", bus.remainder); end
        nVec++; if (bus.div_by_zero !== 1'b0) begin nErr++; $display("[TB] FAIL reset_dbz: got %b expected 0", bus.div_by_zero); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, busyCnt, pulses;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic dz;
        exp_t e;
        run_op(DW'(1000), VW'(7), -1, -1, -1, lat, busyCnt, pulses, q, r, dz);
        e = sb.pop_front();
        nVec++; if (lat !== e.lat) begin nErr++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, e.lat); end
        nVec++; if (q !== e.quot) begin nErr++; $display("[TB] FAIL basic_quot: got %0d expected %0d", q, e.quot); end
        nVec++; if (r !== e.rem) begin nErr++; $display("[TB] FAIL basic_rem: got %0d expected %0d", r, e.rem); end
        nVec++; if (dz !== e.dbz) begin nErr++; $display("[TB] FAIL basic_dbz: got %b expected %b", dz, e.dbz); end
        nVec++; if (busyCnt !== 11) begin nErr++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 11", busyCnt); end
        nVec++; if (pulses !== 1) begin nErr++; $display("[TB] FAIL basic_done_pulses: got %0d expected 1", pulses); end
        repeat (2) @(posedge clk);
        #1;
        nVec++; if (bus.quotient !== e.quot) begin nErr++; $display("[TB] FAIL basic_quot_held: got %0d expected %0d", bus.quotient, e.quot); end
        nVec++; if (bus.remainder !== e.rem) begin nErr++; $display("[TB] FAIL basic_rem_held: got %0d expected %0d", bus.remainder, e.rem); end
    endtask

    task automatic test_operands();
        int lat, busyCnt, pulses;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic dz;
        exp_t e;
        run_op(DW'(1023), VW'(15), -1, -1, -1, lat, busyCnt, pulses, q, r, dz);
        e = sb.pop_front();
        nVec++; if (q !== e.quot) begin nErr++; $display("[TB] FAIL max_quot: got %0d expected %0d", q, e.quot); end
        nVec++; if (r !== e.rem) begin nErr++; $display("[TB] FAIL max_rem: got %0d expected %0d", r, e.rem); end
        run_op(DW'(5), VW'(9), -1, -1, -1, lat, busyCnt, pulses, q, r, dz);
        e = sb.pop_front();
        nVec++; if (q !== e.quot) begin nErr++; $display("[TB] FAIL small_quot: got %0d expected %0d", q, e.quot); end
        nVec++; if (r !== e.rem) begin nErr++; $display("[TB] FAIL small_rem: got %0d expected %0d", r, e.rem); end
        nVec++; if (lat !== e.lat) begin nErr++; $display("[TB] FAIL small_latency: got %0d expected %0d", lat, e.lat); end
    endtask

    task automatic test_div_zero();
        int lat, busyCnt, pulses;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic dz;
        exp_t e;
        run_op(DW'(300), VW'(0), -1, -1, -1, lat, busyCnt, pulses, q, r, dz);
        e = sb.pop_front();
        nVec++; if (lat !== e.lat) begin nErr++; $display("[TB] FAIL div0_latency: got %0d expected %0d", lat, e.lat); end
        nVec++; if (q !== e.quot) begin nErr++; $display("[TB] FAIL div0_quot: got %0d expected %0d", q, e.quot); end
        nVec++; if (r !== e.rem) begin nErr++; $display("[TB] FAIL div0_rem: got %0d expected %0d", r, e.rem); end
        nVec++; if (dz !== e.dbz) begin nErr++; $display("[TB] FAIL div0_flag: got %b expected %b", dz, e.dbz); end
        nVec++; if (busyCnt !== 1) begin nErr++; $display("[TB] FAIL div0_busy_cycles: got %0d expected 1", busyCnt); end
        nVec++; if (bus.div_by_zero !== 1'b1) begin nErr++; $display("[TB] FAIL div0_flag_held: got %b expected 1", bus.div_by_zero); end
        run_op(DW'(100), VW'(10), -1, -1, -1, lat, busyCnt, pulses, q, r, dz);
        e = sb.pop_front();
        nVec++; if (q !== e.quot) begin nErr++; $display("[TB] FAIL after_div0_quot: got %0d expected %0d", q, e.quot); end
        nVec++; if (r !== e.rem) begin nErr++; $display("[TB] FAIL after_div0_rem: got %0d expected %0d", r, e.rem); end
        nVec++; if (dz !== e.dbz) begin nErr++; $display("[TB] FAIL after_div0_flag: got %b expected %b", dz, e.dbz); end
    endtask

    task automatic test_busy_ignore();
        int lat, busyCnt, pulses;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic dz;
        exp_t e;
        run_op(DW'(1000), VW'(7), 2, 9, -1, lat, busyCnt, pulses, q, r, dz);
        e = sb.pop_front();
        nVec++; if (q !== e.quot) begin nErr++; $display("[TB] FAIL ignore_quot: got %0d expected %0d", q, e.quot); end
        nVec++; if (r !== e.rem) begin nErr++; $display("[TB] FAIL ignore_rem: got %0d expected %0d", r, e.rem); end
        nVec++; if (lat !== e.lat) begin nErr++; $display("[TB] FAIL ignore_latency: got %0d expected %0d", lat, e.lat); end
        nVec++; if (pulses !== 1) begin nErr++; $display("[TB] FAIL ignore_done_pulses: got %0d expected 1", pulses); end
        nVec++; if (busyCnt !== 11) begin nErr++; $display("[TB] FAIL ignore_busy_cycles: got %0d expected 11", busyCnt); end
    endtask

    task automatic test_abort();
        int lat, busyCnt, pulses;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic dz;
        exp_t e;
        run_op(DW'(1000), VW'(7), -1, -1, 4, lat, busyCnt, pulses, q, r, dz);
        nVec++; if (bus.busy !== 1'b0) begin nErr++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); end
        nVec++; if (bus.done !== 1'b0) begin nErr++; $display("[TB] FAIL abort_done: got %b expected 0", bus.done); end
        nVec++; if (bus.quotient !== '0) begin nErr++; $display("[TB] FAIL abort_quot: got %0d expected 0", bus.quotient); end
        nVec++; if (bus.remainder !== '0) begin nErr++; $display("[TB] FAIL abort_rem: got %0d expected 0", bus.remainder); end
        nVec++; if (pulses !== 0) begin nErr++; $display("[TB] FAIL abort_done_pulses: got %0d expected 0", pulses); end
        repeat (2) @(posedge clk);
        #1;
        nVec++; if (bus.done !== 1'b0) begin nErr++; $display("[TB] FAIL abort_done_in_reset: got %b expected 0", bus.done); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(DW'(512), VW'(2), -1, -1, -1, lat, busyCnt, pulses, q, r, dz);
        e = sb.pop_front();
        nVec++; if (q !== e.quot) begin nErr++; $display("[TB] FAIL post_abort_quot: got %0d expected %0d", q, e.quot); end
        nVec++; if (r !== e.rem) begin nErr++; $display("[TB] FAIL post_abort_rem: got %0d expected %0d", r, e.rem); end
        nVec++; if (lat !== e.lat) begin nErr++; $display("[TB] FAIL post_abort_latency: got %0d expected %0d", lat, e.lat); end
    endtask

    task automatic test_back_to_back();
        int   lastDone;
        int   pulses;
        exp_t e;
        exp_t held;
        for (int k = 0; k < 3; k++) pushExpected(DW'(999), VW'(3));
        held.quot = '0;
        held.rem  = '0;
        lastDone  = -1;
        pulses    = 0;
        bus.dividend = DW'(999);
        bus.divisor  = VW'(3);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 36; cyc++) begin
            if (bus.done === 1'b1) begin
                pulses++;
                if (sb.size() == 0) begin
                    nVec++; nErr++;
                    $display("[TB] FAIL b2b_extra_done: got pulse %0d expected 3 pulses", pulses);
                end else begin
                    e = sb.pop_front();
                    held = e;
                    nVec++; if (bus.quotient !== e.quot) begin nErr++; $display("[TB] FAIL b2b_quot: got %0d expected %0d", bus.quotient, e.quot); end
                    nVec++; if (bus.remainder !== e.rem) begin nErr++; $display("[TB] FAIL b2b_rem: got %0d expected %0d", bus.remainder, e.rem); end
                end
                if (lastDone >= 0) begin
                    nVec++; if (cyc - lastDone !== 12) begin nErr++; $display("[TB] FAIL b2b_period: got %0d expected 12", cyc - lastDone); end
                end
                lastDone = cyc;
            end else if (lastDone >= 0 && cyc == lastDone + 1) begin
                nVec++; if (bus.busy !== 1'b0) begin nErr++; $display("[TB] FAIL b2b_idle_gap: got busy %b expected 0", bus.busy); end
                nVec++; if (bus.quotient !== held.quot) begin nErr++; $display("[TB] FAIL b2b_quot_stable: got %0d expected %0d", bus.quotient, held.quot); end
            end
            if (cyc == 35) bus.start = 1'b0;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        nVec++; if (pulses !== 3) begin nErr++; $display("[TB] FAIL b2b_done_pulses: got %0d expected 3", pulses); end
        sb.delete();
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        $display("[TB] starting seq_divider_10bit scenarios");
        test_reset();
        test_basic();
        test_operands();
        test_div_zero();
        test_busy_ignore();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
